// File: rtl/layer1_maxpool_pkg.sv
// Shared constants for the layer-1 max-pool stage.
// The csel codes match the ones the conv engine drives on the shared bus.
package layer1_maxpool_pkg;

    localparam int DATA_WIDTH  = 20;
    localparam int ADDR_WIDTH  = 12;
    localparam int IMAGE_WIDTH = 64;
    localparam int OUT_WIDTH   = IMAGE_WIDTH / 2;
    localparam int IN_BITS     = $clog2(IMAGE_WIDTH);
    localparam int OUT_BITS    = $clog2(OUT_WIDTH);

    localparam logic [2:0] CSEL_IDLE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    localparam logic [2:0] K_LAST = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } pool_state_e;

endpackage

// File: rtl/pool_window_addr_gen.sv
// Window/tap counters for 2x2 stride-2 pooling.
// Generates the layer-0 tap address and the layer-1 result address.
module pool_window_addr_gen
    import layer1_maxpool_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  k_inc,
    input  logic                  win_adv,
    output logic [2:0]            k,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  last_window
);

    logic [2:0]          k_q, k_d;
    logic [OUT_BITS-1:0] orow_q, orow_d;
    logic [OUT_BITS-1:0] ocol_q, ocol_d;
    logic [IN_BITS-1:0]  row, col;

    always_comb begin
        k_d    = k_q;
        orow_d = orow_q;
        ocol_d = ocol_q;
        if (clear) begin
            k_d    = '0;
            orow_d = '0;
            ocol_d = '0;
        end else if (win_adv) begin
            k_d    = '0;
            ocol_d = ocol_q + 1'b1;
            if (ocol_q == OUT_BITS'(OUT_WIDTH - 1)) begin
                orow_d = orow_q + 1'b1;
            end
        end else if (k_inc) begin
            k_d = k_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q    <= '0;
            orow_q <= '0;
            ocol_q <= '0;
        end else begin
            k_q    <= k_d;
            orow_q <= orow_d;
            ocol_q <= ocol_d;
        end
    end

    // Tap k: bit 0 selects the right column, bit 1 the lower row.
    assign row = {orow_q, k_q[1]};
    assign col = {ocol_q, k_q[0]};

    assign k           = k_q;
    assign rd_addr     = ADDR_WIDTH'(row) * ADDR_WIDTH'(IMAGE_WIDTH)
                       + ADDR_WIDTH'(col);
    assign wr_addr     = ADDR_WIDTH'(orow_q) * ADDR_WIDTH'(OUT_WIDTH)
                       + ADDR_WIDTH'(ocol_q);
    assign last_window = (orow_q == OUT_BITS'(OUT_WIDTH - 1))
                      && (ocol_q == OUT_BITS'(OUT_WIDTH - 1));

endmodule

// File: rtl/layer1_maxpool.sv
// 2x2 stride-2 max-pool of layer-0 (64x64) into layer-1 (32x32).
// Shares the layer memory bus with the conv engine once start is pulsed.
module layer1_maxpool
    import layer1_maxpool_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  crd,
    output logic [ADDR_WIDTH-1:0] caddr_rd,
    input  logic [DATA_WIDTH-1:0] cdata_rd,
    output logic                  cwr,
    output logic [ADDR_WIDTH-1:0] caddr_wr,
    output logic [DATA_WIDTH-1:0] cdata_wr,
    output logic [2:0]            csel
);

    pool_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [ADDR_WIDTH-1:0] rd_hold_q, rd_hold_d;
    logic [ADDR_WIDTH-1:0] wr_hold_q, wr_hold_d;
    logic [DATA_WIDTH-1:0] data_hold_q, data_hold_d;

    logic [2:0]            k;
    logic [ADDR_WIDTH-1:0] gen_rd, gen_wr;
    logic                  last_window;
    logic                  clear, k_inc, win_adv;

    pool_window_addr_gen u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .k_inc       (k_inc),
        .win_adv     (win_adv),
        .k           (k),
        .rd_addr     (gen_rd),
        .wr_addr     (gen_wr),
        .last_window (last_window)
    );

    // Read data lags its address by one cycle, so tap k lands at k+1.
    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        busy    = 1'b0;
        done    = 1'b0;
        crd     = 1'b0;
        cwr     = 1'b0;
        clear   = 1'b0;
        k_inc   = 1'b0;
        win_adv = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                clear = 1'b1;
                if (start) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                busy  = 1'b1;
                k_inc = 1'b1;
                crd   = (k != K_LAST);
                if (k == 3'd1) begin
                    max_d = cdata_rd;
                end else if ((k >= 3'd2) && (cdata_rd > max_q)) begin
                    max_d = cdata_rd;
                end
                if (k == K_LAST) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                busy    = 1'b1;
                cwr     = 1'b1;
                win_adv = 1'b1;
                state_d = last_window ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                clear   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        csel        = crd ? CSEL_L0 : (cwr ? CSEL_L1 : CSEL_IDLE);
        caddr_rd    = crd ? gen_rd : rd_hold_q;
        caddr_wr    = cwr ? gen_wr : wr_hold_q;
        cdata_wr    = cwr ? max_q : data_hold_q;
        rd_hold_d   = caddr_rd;
        wr_hold_d   = caddr_wr;
        data_hold_d = cdata_wr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            max_q       <= '0;
            rd_hold_q   <= '0;
            wr_hold_q   <= '0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            max_q       <= max_d;
            rd_hold_q   <= rd_hold_d;
            wr_hold_q   <= wr_hold_d;
            data_hold_q <= data_hold_d;
        end
    end

endmodule

// File: tb/tb_layer1_maxpool.sv
// Randomised bench for layer1_maxpool against an array-based pooling model.
// Layer-0 memory answers reads one cycle late; writes are captured in order.
module tb_layer1_maxpool;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic [2:0]  csel;

    layer1_maxpool dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    always #5 clk = ~clk;

    logic [19:0] l0 [4096];
    logic [19:0] exp_l1 [1024];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int busy_cnt, done_cnt;
    int first_busy_cyc, first_wr_cyc, last_wr_cyc, done_cyc;
    bit busy_prev = 1'b0;
    int wr_addr_q [$];
    int wr_data_q [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Garbage when not reading, so stale-data use shows up.
    always @(posedge clk) begin
        if (crd) cdata_rd <= l0[caddr_rd];
        else     cdata_rd <= 20'($urandom);
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("crd_cwr_excl", 32'(crd & cwr), 32'd0);
            chk("csel_vs_strobe", 32'(csel),
                crd ? 32'd1 : (cwr ? 32'd3 : 32'd0));
            if (busy) begin
                busy_cnt++;
                if (!busy_prev) first_busy_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cwr) begin
                if (wr_addr_q.size() == 0) first_wr_cyc = cyc;
                wr_addr_q.push_back(int'(caddr_wr));
                wr_data_q.push_back(int'(cdata_wr));
                last_wr_cyc = cyc;
            end
        end
        busy_prev = busy;
    end

    task automatic clear_mon();
        busy_cnt = 0;
        done_cnt = 0;
        first_busy_cyc = 0;
        first_wr_cyc = 0;
        last_wr_cyc = 0;
        done_cyc = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic compute_ref();
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                logic [19:0] m;
                m = 0;
                for (int dr = 0; dr < 2; dr++) begin
                    for (int dc = 0; dc < 2; dc++) begin
                        logic [19:0] v;
                        v = l0[(2 * r + dr) * 64 + 2 * c + dc];
                        if (v > m) m = v;
                    end
                end
                exp_l1[r * 32 + c] = m;
            end
        end
    endtask

    task automatic fill_const(input logic [19:0] v);
        for (int i = 0; i < 4096; i++) l0[i] = v;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 4096; i++) l0[i] = 20'(i);
    endtask

    task automatic fill_rand(input int unsigned hi);
        for (int i = 0; i < 4096; i++) l0[i] = 20'($urandom_range(hi, 0));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_crd"}, 32'(crd), 32'd0);
        chk({tag, "_cwr"}, 32'(cwr), 32'd0);
        chk({tag, "_csel"}, 32'(csel), 32'd0);
        chk({tag, "_caddr_rd"}, 32'(caddr_rd), 32'd0);
        chk({tag, "_caddr_wr"}, 32'(caddr_wr), 32'd0);
        chk({tag, "_cdata_wr"}, 32'(cdata_wr), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_full(input string tag, input int extra_start_at);
        int n;
        compute_ref();
        clear_mon();
        pulse_start();
        for (int i = 0; i < 7000 && done_cnt == 0; i++) begin
            @(negedge clk);
            start = (extra_start_at != 0 && i == extra_start_at);
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
        repeat (4) @(negedge clk);
        chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd6145);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'd1024);
        chk({tag, "_first_wr_lat"}, 32'(first_wr_cyc - first_busy_cyc), 32'd5);
        chk({tag, "_done_lat"}, 32'(done_cyc - last_wr_cyc), 32'd1);
        n = (wr_addr_q.size() < 1024) ? wr_addr_q.size() : 1024;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_wr_addr"}, 32'(wr_addr_q[i]), 32'(i));
            chk({tag, "_wr_data"}, 32'(wr_data_q[i]), 32'(exp_l1[i]));
        end
    endtask

    task automatic run_first_window(input string tag, input logic [19:0] exp);
        clear_mon();
        pulse_start();
        for (int i = 0; i < 20 && wr_addr_q.size() == 0; i++) @(negedge clk);
        chk({tag, "_wr_seen"}, 32'(wr_addr_q.size() > 0), 32'd1);
        if (wr_addr_q.size() > 0) begin
            chk({tag, "_addr"}, 32'(wr_addr_q[0]), 32'd0);
            chk({tag, "_data"}, 32'(wr_data_q[0]), 32'(exp));
        end
        do_reset();
        @(negedge clk);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int taps [4];
        taps = '{0, 1, 64, 65};
        reset = 1'b1;
        start = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_reset", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", 32'(busy), 32'd0);

        fill_const(20'd0);
        run_full("t1_zero", 0);

        fill_ramp();
        run_full("t2_ramp", 0);
        if (wr_data_q.size() == 1024) begin
            chk("t2_l1_first", 32'(wr_data_q[0]), 32'd65);
            chk("t2_l1_last", 32'(wr_data_q[1023]), 32'd4095);
        end

        for (int t = 0; t < 4; t++) begin
            fill_rand(20'h00fff);
            l0[0] = 20'd9;
            l0[1] = 20'd3;
            l0[64] = 20'd5;
            l0[65] = 20'd1;
            if (t > 0) l0[taps[t]] = 20'hfffff;
            run_first_window($sformatf("t3_tap%0d", t),
                             (t == 0) ? 20'd9 : 20'hfffff);
        end

        fill_rand(20'hfffff);
        run_full("rand_full", 0);

        fill_rand(3);
        run_full("rand_ties", 0);

        fill_rand(20'hfffff);
        compute_ref();
        clear_mon();
        pulse_start();
        for (int i = 0; i < 7000 && wr_addr_q.size() < 100; i++) @(negedge clk);
        chk("t4_reached_w100", 32'(wr_addr_q.size()), 32'd100);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("t4_reset");
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("t4_no_w100", 32'(wr_addr_q.size()), 32'd100);
        chk("t4_idle", 32'(busy), 32'd0);
        run_full("t4_rerun", 0);

        fill_ramp();
        run_full("t5_restart", 3000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
